multicycle_datapath: RTL and testbench

//  Multi-cycle MIPS-subset datapath with an internal step sequencer; successor to the single-cycle datapath.

---
 rtl/dp_pkg.sv | 31 +++
 rtl/dp_regfile.sv | 32 +++
 rtl/multicycle_datapath.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_datapath.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// Shared definitions for the multi-cycle datapath.
//   state_t  : sequencer step encodings (state_out exposes these values)
//   alu_op_t : ALU_Control operation codes driven by the external decoder
//   RESET_PC_DEFAULT : default fetch address after reset
//   sext16   : sign-extends a 16-bit immediate to 32 bits
package dp_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/dp_regfile.sv
// 32 x 32-bit register file: two asynchronous read ports, one synchronous
// write port, asynchronous active-low clear.
//   clk, rst      : clock / async active-low clear of all registers
//   ra1, ra2      : read addresses -> rd1, rd2 (register 0 always reads 0)
//   we, wa, wd    : write enable / address / data (writes to register 0 dropped)
// A read of the register being written returns the old contents.
module dp_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS-subset datapath with internal IF/ID/EX/MEM/WB sequencer.
// Instruction and data memories are reached over req/ack buses with
// variable latency; a wait that exceeds TIMEOUT_CYC cycles halts the core
// (state S_HALT, sticky err) until reset.
// Ports:
//   clk, rst                 : clock, async active-low reset
//   imem_req/addr/ack/rdata  : instruction fetch bus (addr = PC)
//   inst_out                 : instruction register, to external decoder
//   RegDst..MemWrite, ALU_Control : decoded controls from external decoder
//   dmem_req/we/addr/wdata/ack/rdata : data bus (addr = ALUOut, wdata = B)
//   PC_out, state_out        : current PC and sequencer state (debug)
//   err                      : sticky bus-timeout flag
//   exc                      : one-cycle overflow-trap pulse
// Build option: define OVF_TRAP_EN to trap signed overflow on register-
// writing ALU ops (PC <= TRAP_VEC, writeback suppressed); otherwise
// overflow wraps silently and exc stays 0.
module multicycle_datapath
  import dp_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter logic [31:0] TRAP_VEC    = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  input  logic        RegDst,
  input  logic        ALUSrc_B,
  input  logic        MemtoReg,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        RegWrite,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  ALU_Control,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] PC_out,
  output logic [2:0]  state_out,
  output logic        err,
  output logic        exc
);

  state_t      state, state_nxt;
  logic [31:0] pc, ir, a, b, alu_out, mdr;
  logic [31:0] wait_cnt;
  logic        req_en, err_q, exc_q;
  logic [31:0] imm_sext, alu_b, alu_y, rd_a, rd_b;
  logic        zero, timeout, trap;

  assign imm_sext = sext16(ir[15:0]);
  assign zero     = (alu_y == '0);
  assign timeout  = (wait_cnt == TIMEOUT_CYC - 1);

  always_comb begin
    alu_b = ALUSrc_B ? imm_sext : b;
    alu_y = '0;
    case (ALU_Control)
      ALU_AND: alu_y = a & alu_b;
      ALU_OR:  alu_y = a | alu_b;
      ALU_ADD: alu_y = a + alu_b;
      ALU_SUB: alu_y = a - alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(a) < $signed(alu_b)};
      default: alu_y = '0;
    endcase
  end

`ifdef OVF_TRAP_EN
  logic ovf;
  always_comb begin
    ovf = 1'b0;
    if (ALU_Control == ALU_ADD)
      ovf = (a[31] == alu_b[31]) && (alu_y[31] != a[31]);
    else if (ALU_Control == ALU_SUB)
      ovf = (a[31] != alu_b[31]) && (alu_y[31] != a[31]);
  end
  assign trap = ovf && RegWrite;
`else
  assign trap = 1'b0;
`endif

  dp_regfile u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (ir[25:21]),
    .ra2 (ir[20:16]),
    .we  (state == S_WB),
    .wa  (RegDst ? ir[15:11] : ir[20:16]),
    .wd  (MemtoReg ? mdr : alu_out),
    .rd1 (rd_a),
    .rd2 (rd_b)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IF:   if (imem_ack) state_nxt = S_ID;
              else if (timeout) state_nxt = S_HALT;
      S_ID:   state_nxt = S_EX;
      S_EX:   if (Jump || Branch || trap) state_nxt = S_IF;
              else if (MemRead || MemWrite) state_nxt = S_MEM;
              else if (RegWrite) state_nxt = S_WB;
              else state_nxt = S_IF;
      S_MEM:  if (dmem_ack) state_nxt = MemWrite ? S_IF : S_WB;
              else if (timeout) state_nxt = S_HALT;
      S_WB:   state_nxt = S_IF;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IF;
      pc       <= RESET_PC;
      ir       <= '0;
      a        <= '0;
      b        <= '0;
      alu_out  <= '0;
      mdr      <= '0;
      wait_cnt <= '0;
      req_en   <= 1'b0;
      err_q    <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      req_en <= 1'b1;
      exc_q  <= 1'b0;
      // Any state change restarts the wait count, so entering S_IF/S_MEM
      // always begins at zero.
      if (state_nxt != state) wait_cnt <= '0;
      else if (state == S_IF || state == S_MEM) wait_cnt <= wait_cnt + 32'd1;
      if (state_nxt == S_HALT) err_q <= 1'b1;
      case (state)
        S_IF: if (imem_ack) begin
          ir <= imem_rdata;
          pc <= pc + 32'd4;
        end
        S_ID: begin
          a <= rd_a;
          b <= rd_b;
        end
        S_EX: begin
          alu_out <= alu_y;
          if (Jump) pc <= {pc[31:28], ir[25:0], 2'b00};
          else if (Branch) begin
            if (zero) pc <= pc + {imm_sext[29:0], 2'b00};
          end else if (trap) begin
            pc    <= TRAP_VEC;
            exc_q <= 1'b1;
          end
        end
        S_MEM: if (dmem_ack && !MemWrite) mdr <= dmem_rdata;
        default: ;
      endcase
    end
  end

  // req_en keeps the fetch request low while reset is applied, since the
  // sequencer already sits in S_IF during reset.
  assign imem_req   = (state == S_IF) && req_en;
  assign imem_addr  = pc;
  assign inst_out   = ir;
  assign dmem_req   = (state == S_MEM);
  assign dmem_we    = (state == S_MEM) && MemWrite;
  assign dmem_addr  = alu_out;
  assign dmem_wdata = b;
  assign PC_out     = pc;
  assign state_out  = state;
  assign err        = err_q;
  assign exc        = exc_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
module tb_multicycle_datapath;
  import dp_pkg::*;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int unsigned TIMEOUT_CYC = 16;
  localparam logic [31:0] TRAP_VEC    = 32'h0000_0180;

  logic        clk, rst;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, err, exc;
  logic [31:0] imem_addr, imem_rdata, inst_out, dmem_addr, dmem_wdata, dmem_rdata, PC_out;
  logic        RegDst, ALUSrc_B, MemtoReg, Jump, Branch, RegWrite, MemRead, MemWrite;
  logic [2:0]  ALU_Control, state_out;

  multicycle_datapath #(.RESET_PC(RESET_PC), .TIMEOUT_CYC(TIMEOUT_CYC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_out(inst_out), .RegDst(RegDst), .ALUSrc_B(ALUSrc_B),
    .MemtoReg(MemtoReg), .Jump(Jump), .Branch(Branch), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .ALU_Control(ALU_Control), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .PC_out(PC_out), .state_out(state_out), .err(err), .exc(exc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic reg_dst, alu_src_b, mem_to_reg, jump, branch, reg_write, mem_read, mem_write;
    logic [2:0] alu;
  } ctrl_t;
  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } txn_t;

  txn_t        exp_q[$];
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] exp_pc;

  function automatic ctrl_t mk(input logic rd, as, m2r, j, br, rw, mr, mw, input logic [2:0] op);
    return ctrl_t'({rd, as, m2r, j, br, rw, mr, mw, op});
  endfunction
  function automatic ctrl_t c_r(input logic [2:0] op); return mk(1,0,0,0,0,1,0,0,op); endfunction
  function automatic ctrl_t c_addi(); return mk(0,1,0,0,0,1,0,0,3'(ALU_ADD)); endfunction
  function automatic ctrl_t c_lw();   return mk(0,1,1,0,0,1,1,0,3'(ALU_ADD)); endfunction
  function automatic ctrl_t c_sw();   return mk(0,1,0,0,0,0,0,1,3'(ALU_ADD)); endfunction
  function automatic ctrl_t c_beq();  return mk(0,0,0,0,1,0,0,0,3'(ALU_SUB)); endfunction
  function automatic ctrl_t c_j();    return mk(0,0,0,1,0,0,0,0,3'(ALU_AND)); endfunction
  function automatic ctrl_t c_nop();  return mk(0,0,0,0,0,0,0,0,3'(ALU_AND)); endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd);
    return {6'h00, rs, rt, rd, 5'h00, 6'h20};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  // Plays imem, decoder and dmem for one instruction; returns what was seen.
  task automatic run_instr(input logic [31:0] instr, input ctrl_t c, input int unsigned iwait,
                           input int unsigned dwait, input logic [31:0] ldata,
                           output logic ok, output logic seen, output txn_t got,
                           output int unsigned req_cycles, output int unsigned cycles,
                           output int unsigned exc_cnt, output logic req_gap);
    int unsigned n;
    ok = 1'b0; seen = 1'b0; got = '0; req_cycles = 0; cycles = 0; exc_cnt = 0; req_gap = 1'b0;
    n = 0;
    while (!imem_req && n < 40) begin @(negedge clk); n++; end
    if (!imem_req) return;
    repeat (iwait) @(negedge clk);
    imem_ack = 1'b1; imem_rdata = instr;
    {RegDst, ALUSrc_B, MemtoReg, Jump, Branch, RegWrite, MemRead, MemWrite, ALU_Control} = c;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = '0;
    req_gap = !imem_req;
    cycles = 1;
    while (!imem_req && state_out != 3'd7 && cycles < 60) begin
      if (exc) exc_cnt++;
      if (dmem_req) begin
        req_cycles++;
        seen = 1'b1; got.we = dmem_we; got.addr = dmem_addr; got.wdata = dmem_wdata;
        dmem_ack = (req_cycles == dwait + 1);
        dmem_rdata = dmem_ack ? ldata : '0;
      end else begin
        dmem_ack = 1'b0; dmem_rdata = '0;
      end
      @(negedge clk);
      cycles++;
    end
    dmem_ack = 1'b0; dmem_rdata = '0;
    if (exc) exc_cnt++;
    ok = imem_req;
  endtask

  task automatic test_reset();
    rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    {RegDst, ALUSrc_B, MemtoReg, Jump, Branch, RegWrite, MemRead, MemWrite, ALU_Control} = '0;
    repeat (2) @(negedge clk);
    compared++; if (PC_out !== RESET_PC) begin mismatched++; $display("FAIL rst_pc: got %h want %h", PC_out, RESET_PC); end
    compared++; if (state_out !== 3'd0) begin mismatched++; $display("FAIL rst_state: got %0d want 0", state_out); end
    compared++; if ({imem_req, dmem_req, dmem_we, err, exc} !== 5'b0) begin mismatched++; $display("FAIL rst_outs: got %b want 00000", {imem_req, dmem_req, dmem_we, err, exc}); end
    compared++; if (inst_out !== 32'h0) begin mismatched++; $display("FAIL rst_ir: got %h want 0", inst_out); end
    rst = 1'b1;
    exp_pc = RESET_PC;
  endtask

  task automatic test_alu();
    logic ok, seen, gap; txn_t got, e; int unsigned rq, cyc, ex;
    logic [4:0] rs [6], rt [6], rd [6]; logic [2:0] op [6]; logic [31:0] want [6];
    rs = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd2}; rt = '{5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd1};
    rd = '{5'd3, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9};
    op = '{3'(ALU_ADD), 3'(ALU_SUB), 3'(ALU_AND), 3'(ALU_OR), 3'(ALU_SLT), 3'(ALU_SLT)};
    want = '{32'd12, 32'hFFFF_FFFE, 32'd5, 32'd7, 32'd1, 32'd0};
    run_instr(enc_i(6'h08, 5'd0, 5'd1, 16'd5), c_addi(), 0, 0, '0, ok, seen, got, rq, cyc, ex, gap);
    exp_pc += 4;
    compared++; if (!ok || cyc !== 4) begin mismatched++; $display("FAIL addi_lat: got %0d ok=%b want 4", cyc, ok); end
    compared++; if (PC_out !== RESET_PC + 32'd4) begin mismatched++; $display("FAIL first_pc: got %h want %h", PC_out, RESET_PC + 32'd4); end
    compared++; if (inst_out !== 32'h2001_0005) begin mismatched++; $display("FAIL ir_latch: got %h want 20010005", inst_out); end
    compared++; if (gap !== 1'b1) begin mismatched++; $display("FAIL req_gap: got %b want 1", gap); end
    run_instr(enc_i(6'h08, 5'd0, 5'd2, 16'd7), c_addi(), 2, 0, '0, ok, seen, got, rq, cyc, ex, gap);
    exp_pc += 4;
    compared++; if (!ok || cyc !== 4) begin mismatched++; $display("FAIL addi_wait_lat: got %0d ok=%b want 4", cyc, ok); end
    for (int i = 0; i < 6; i++) begin
      run_instr(enc_r(rs[i], rt[i], rd[i]), c_r(op[i]), 0, 0, '0, ok, seen, got, rq, cyc, ex, gap);
      exp_pc += 4;
      compared++; if (!ok || cyc !== 4 || PC_out !== exp_pc) begin mismatched++; $display("FAIL rtype[%0d]: got lat %0d pc %h want 4 %h", i, cyc, PC_out, exp_pc); end
    end
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{we: 1'b1, addr: 32'(4 * i), wdata: want[i]});
      run_instr(enc_i(6'h2B, 5'd0, rd[i], 16'(4 * i)), c_sw(), 0, i % 3, '0, ok, seen, got, rq, cyc, ex, gap);
      exp_pc += 4;
      e = exp_q.pop_front();
      compared++; if (!seen || got !== e) begin mismatched++; $display("FAIL store[%0d]: got we=%b a=%h d=%h want we=%b a=%h d=%h", i, got.we, got.addr, got.wdata, e.we, e.addr, e.wdata); end
      compared++; if (!ok || cyc !== 4 + (i % 3)) begin mismatched++; $display("FAIL store_lat[%0d]: got %0d want %0d", i, cyc, 4 + (i % 3)); end
    end
  endtask

  task automatic test_load();
    logic ok, seen, gap; txn_t got, e; int unsigned rq, cyc, ex;
    exp_q.push_back('{we: 1'b0, addr: 32'd8, wdata: 32'd0});
    run_instr(enc_i(6'h23, 5'd0, 5'd4, 16'd8), c_lw(), 0, 3, 32'hDEAD_BEEF, ok, seen, got, rq, cyc, ex, gap);
    exp_pc += 4;
    e = exp_q.pop_front();
    compared++; if (!seen || got !== e) begin mismatched++; $display("FAIL load_txn: got we=%b a=%h want we=%b a=%h", got.we, got.addr, e.we, e.addr); end
    compared++; if (rq !== 4) begin mismatched++; $display("FAIL load_req_hold: got %0d want 4", rq); end
    compared++; if (!ok || cyc !== 8) begin mismatched++; $display("FAIL load_lat: got %0d want 8", cyc); end
    exp_q.push_back('{we: 1'b1, addr: 32'd12, wdata: 32'hDEAD_BEEF});
    run_instr(enc_i(6'h2B, 5'd0, 5'd4, 16'd12), c_sw(), 1, 0, '0, ok, seen, got, rq, cyc, ex, gap);
    exp_pc += 4;
    e = exp_q.pop_front();
    compared++; if (!seen || got !== e) begin mismatched++; $display("FAIL load_result: got d=%h want d=%h", got.wdata, e.wdata); end
  endtask

  task automatic test_branch_jump();
    logic ok, seen, gap; txn_t got, e; int unsigned rq, cyc, ex;
    logic [31:0] instr [7]; ctrl_t ctl [7]; logic [31:0] tgt [7];
    instr = '{enc_j(26'h4), enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF), enc_i(6'h04, 5'd1, 5'd2, 16'hFFFF),
              enc_i(6'h04, 5'd0, 5'd0, 16'd2), enc_j(26'h3FF_FFFF), 32'h0, enc_j(26'h40)};
    ctl  = '{c_j(), c_beq(), c_beq(), c_beq(), c_j(), c_nop(), c_j()};
    tgt  = '{32'h10, 32'h10, 32'h14, 32'h20, 32'h0FFF_FFFC, 32'h1000_0000, 32'h1000_0100};
    for (int i = 0; i < 7; i++) begin
      run_instr(instr[i], ctl[i], 0, 0, '0, ok, seen, got, rq, cyc, ex, gap);
      compared++; if (!ok || cyc !== 3 || PC_out !== tgt[i]) begin mismatched++; $display("FAIL flow[%0d]: got lat %0d pc %h want 3 %h", i, cyc, PC_out, tgt[i]); end
    end
    exp_pc = 32'h1000_0100;
    run_instr(enc_i(6'h08, 5'd1, 5'd0, 16'd9), c_addi(), 0, 0, '0, ok, seen, got, rq, cyc, ex, gap);
    exp_pc += 4;
    exp_q.push_back('{we: 1'b1, addr: 32'd16, wdata: 32'd0});
    run_instr(enc_i(6'h2B, 5'd0, 5'd0, 16'd16), c_sw(), 0, 0, '0, ok, seen, got, rq, cyc, ex, gap);
    exp_pc += 4;
    e = exp_q.pop_front();
    compared++; if (!seen || got !== e) begin mismatched++; $display("FAIL reg0: got d=%h want d=%h", got.wdata, e.wdata); end
  endtask

  task automatic test_overflow();
    logic ok, seen, gap; txn_t got, e; int unsigned rq, cyc, ex;
    run_instr(enc_i(6'h23, 5'd0, 5'd9, 16'd0), c_lw(), 0, 0, 32'h7FFF_FFFF, ok, seen, got, rq, cyc, ex, gap);
    run_instr(enc_i(6'h08, 5'd0, 5'd11, 16'd3), c_addi(), 0, 0, '0, ok, seen, got, rq, cyc, ex, gap);
    exp_pc += 8;
    run_instr(enc_i(6'h08, 5'd9, 5'd11, 16'd1), c_addi(), 0, 0, '0, ok, seen, got, rq, cyc, ex, gap);
`ifdef OVF_TRAP_EN
    exp_pc = TRAP_VEC;
    compared++; if (ex !== 1 || cyc !== 3) begin mismatched++; $display("FAIL ovf_trap: got exc %0d lat %0d want 1 3", ex, cyc); end
    exp_q.push_back('{we: 1'b1, addr: 32'd20, wdata: 32'd3});
`else
    exp_pc += 4;
    compared++; if (ex !== 0 || cyc !== 4) begin mismatched++; $display("FAIL ovf_wrap: got exc %0d lat %0d want 0 4", ex, cyc); end
    exp_q.push_back('{we: 1'b1, addr: 32'd20, wdata: 32'h8000_0000});
`endif
    compared++; if (PC_out !== exp_pc) begin mismatched++; $display("FAIL ovf_pc: got %h want %h", PC_out, exp_pc); end
    run_instr(enc_i(6'h2B, 5'd0, 5'd11, 16'd20), c_sw(), 0, 0, '0, ok, seen, got, rq, cyc, ex, gap);
    exp_pc += 4;
    e = exp_q.pop_front();
    compared++; if (!seen || got !== e) begin mismatched++; $display("FAIL ovf_dest: got d=%h want d=%h", got.wdata, e.wdata); end
  endtask

  task automatic test_timeout();
    logic ok, seen, gap; txn_t got, e; int unsigned rq, cyc, ex, n;
    run_instr(enc_i(6'h08, 5'd0, 5'd12, 16'd1), c_addi(), TIMEOUT_CYC - 1, 0, '0, ok, seen, got, rq, cyc, ex, gap);
    compared++; if (!ok || err !== 1'b0 || cyc !== 4) begin mismatched++; $display("FAIL ack_at_limit: got ok=%b err=%b lat %0d want 1 0 4", ok, err, cyc); end
    n = 0;
    while (state_out != 3'd7 && n < TIMEOUT_CYC + 8) begin @(negedge clk); n++; end
    compared++; if (n !== TIMEOUT_CYC) begin mismatched++; $display("FAIL halt_cycle: got %0d want %0d", n, TIMEOUT_CYC); end
    compared++; if (err !== 1'b1 || imem_req !== 1'b0 || state_out !== 3'd7) begin mismatched++; $display("FAIL halt_outs: got err=%b req=%b st=%0d want 1 0 7", err, imem_req, state_out); end
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    repeat (2) @(negedge clk);
    imem_ack = 1'b0; imem_rdata = '0;
    compared++; if (state_out !== 3'd7 || err !== 1'b1) begin mismatched++; $display("FAIL halt_absorb: got st=%0d err=%b want 7 1", state_out, err); end
    rst = 1'b0; #1;
    compared++; if (err !== 1'b0 || PC_out !== RESET_PC || state_out !== 3'd0) begin mismatched++; $display("FAIL halt_reset: got err=%b pc=%h st=%0d", err, PC_out, state_out); end
    @(negedge clk); rst = 1'b1;
    n = 0;
    while (!imem_req && n < 5) begin @(negedge clk); n++; end
    #2 rst = 1'b0; #1;
    compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL reset_mid_req: got %b want 0", imem_req); end
    @(negedge clk); rst = 1'b1;
    exp_pc = RESET_PC;
    run_instr(enc_i(6'h08, 5'd0, 5'd1, 16'd5), c_addi(), 0, 0, '0, ok, seen, got, rq, cyc, ex, gap);
    compared++; if (!ok || PC_out !== RESET_PC + 32'd4) begin mismatched++; $display("FAIL post_reset_pc: got %h want %h", PC_out, RESET_PC + 32'd4); end
    exp_q.push_back('{we: 1'b1, addr: 32'd0, wdata: 32'd0});
    run_instr(enc_i(6'h2B, 5'd0, 5'd3, 16'd0), c_sw(), 0, 0, '0, ok, seen, got, rq, cyc, ex, gap);
    e = exp_q.pop_front();
    compared++; if (!seen || got !== e) begin mismatched++; $display("FAIL rf_cleared: got d=%h want d=%h", got.wdata, e.wdata); end
    exp_q.push_back('{we: 1'b1, addr: 32'd4, wdata: 32'd5});
    run_instr(enc_i(6'h2B, 5'd0, 5'd1, 16'd4), c_sw(), 0, 0, '0, ok, seen, got, rq, cyc, ex, gap);
    e = exp_q.pop_front();
    compared++; if (!seen || got !== e) begin mismatched++; $display("FAIL post_reset_wr: got d=%h want d=%h", got.wdata, e.wdata); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_branch_jump();
    test_overflow();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
